// File: rtl/aes_selftest_seq.sv
// AES-over-SPI built-in self-test sequencer. It runs an encrypt/decrypt round-trip
// through SPI_Main for each of three FIPS-197 known-answer vectors.
module aes_selftest_seq #(
    parameter int GAP_CYCLES     = 80,
    parameter int RX_GAP_CYCLES  = 70,
    parameter int TIMEOUT_CYCLES = 8192,
    parameter int CHECK_CT       = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         mode,
    input  logic [1:0]   vec_sel,
    input  logic         spi_done,
    input  logic [0:127] spi_rx,
    output logic         spi_start,
    output logic         spi_sel,
    output logic [0:257] spi_tx,
    output logic         busy,
    output logic         pass,
    output logic         fail,
    output logic [2:0]   fail_code,
    output logic [1:0]   fail_vec,
    output logic [1:0]   vec_pass_cnt
);
    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_KEY    = 4'd1;
    localparam logic [3:0] S_KEY_W  = 4'd2;
    localparam logic [3:0] S_GAP_D  = 4'd3;
    localparam logic [3:0] S_DATA   = 4'd4;
    localparam logic [3:0] S_DATA_W = 4'd5;
    localparam logic [3:0] S_GAP_R  = 4'd6;
    localparam logic [3:0] S_RX     = 4'd7;
    localparam logic [3:0] S_RX_W   = 4'd8;
    localparam logic [3:0] S_CHECK  = 4'd9;
    localparam logic [3:0] S_NEXT   = 4'd10;

    localparam logic [2:0] FC_NONE    = 3'd0;
    localparam logic [2:0] FC_BAD_VEC = 3'd1;
    localparam logic [2:0] FC_TIMEOUT = 3'd2;
    localparam logic [2:0] FC_CT      = 3'd3;
    localparam logic [2:0] FC_PT      = 3'd4;

    // Gap counters stop two short: one edge to enter the issue state, one to raise spi_start.
    localparam logic [15:0] DATA_GAP_LAST = 16'(GAP_CYCLES - 2);
    localparam logic [15:0] RX_GAP_LAST   = 16'(RX_GAP_CYCLES - 2);
    localparam logic [15:0] NEXT_GAP_LAST = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST  = 16'(TIMEOUT_CYCLES - 1);

    localparam logic [127:0] PLAINTEXT = 128'h00112233445566778899aabbccddeeff;

    logic [3:0]   r_state;
    logic [1:0]   r_idx;
    logic         r_phase;
    logic         r_mode;
    logic [15:0]  r_cnt;
    logic         r_done_prev;
    logic [127:0] r_rx;
    logic [127:0] r_ct;
    logic [257:0] r_tx;
    logic         r_spi_start;
    logic         r_busy;
    logic         r_pass;
    logic         r_fail;
    logic [2:0]   r_fail_code;
    logic [1:0]   r_fail_vec;
    logic [1:0]   r_vec_pass_cnt;

    logic [255:0] w_key_full;
    logic [255:0] w_key;
    logic [127:0] w_exp_ct;
    logic         w_done_edge;
    logic         w_abort;
    logic [2:0]   w_abort_code;

    // Key bytes count up from 00; shorter keys are the leading bytes of the 32-byte one.
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_key_byte
            assign w_key_full[8*(31-gi) +: 8] = 8'(gi);
        end
    endgenerate

    always_comb begin
        w_key    = w_key_full;
        w_exp_ct = 128'h8ea2b7ca516745bfeafc49904b496089;
        case (r_idx)
            2'd0: begin
                w_key    = {128'b0, w_key_full[255:128]};
                w_exp_ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
            end
            2'd1: begin
                w_key    = {64'b0, w_key_full[255:64]};
                w_exp_ct = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
            end
            default: ;
        endcase
    end

    assign w_done_edge = spi_done & ~r_done_prev;

    // A done edge on the final timeout cycle wins over the timeout.
    always_comb begin
        w_abort      = 1'b0;
        w_abort_code = FC_NONE;
        case (r_state)
            S_KEY_W, S_DATA_W, S_RX_W: begin
                if (!w_done_edge && (r_cnt == TIMEOUT_LAST)) begin
                    w_abort      = 1'b1;
                    w_abort_code = FC_TIMEOUT;
                end
            end
            S_CHECK: begin
                if (!r_phase && (CHECK_CT != 0) && (r_rx != w_exp_ct)) begin
                    w_abort      = 1'b1;
                    w_abort_code = FC_CT;
                end else if (r_phase && (r_rx != PLAINTEXT)) begin
                    w_abort      = 1'b1;
                    w_abort_code = FC_PT;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_idx          <= 2'd0;
            r_phase        <= 1'b0;
            r_mode         <= 1'b0;
            r_cnt          <= 16'd0;
            r_done_prev    <= 1'b0;
            r_rx           <= '0;
            r_ct           <= '0;
            r_tx           <= '0;
            r_spi_start    <= 1'b0;
            r_busy         <= 1'b0;
            r_pass         <= 1'b0;
            r_fail         <= 1'b0;
            r_fail_code    <= FC_NONE;
            r_fail_vec     <= 2'd0;
            r_vec_pass_cnt <= 2'd0;
        end else begin
            r_done_prev <= spi_done;
            r_spi_start <= 1'b0;
            if (w_abort) begin
                r_fail      <= 1'b1;
                r_fail_code <= w_abort_code;
                r_fail_vec  <= r_idx;
                r_busy      <= 1'b0;
                r_phase     <= 1'b0;
                r_cnt       <= 16'd0;
                r_state     <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_pass         <= 1'b0;
                            r_fail         <= 1'b0;
                            r_fail_code    <= FC_NONE;
                            r_fail_vec     <= 2'd0;
                            r_vec_pass_cnt <= 2'd0;
                            r_phase        <= 1'b0;
                            r_mode         <= mode;
                            r_cnt          <= 16'd0;
                            if (!mode && (vec_sel == 2'd3)) begin
                                r_fail      <= 1'b1;
                                r_fail_code <= FC_BAD_VEC;
                                r_fail_vec  <= vec_sel;
                            end else begin
                                r_idx   <= mode ? 2'd0 : vec_sel;
                                r_busy  <= 1'b1;
                                r_state <= S_KEY;
                            end
                        end
                    end
                    S_KEY: begin
                        r_tx        <= {r_idx, w_key};
                        r_spi_start <= 1'b1;
                        r_cnt       <= 16'd0;
                        r_state     <= S_KEY_W;
                    end
                    S_KEY_W: begin
                        if (w_done_edge) begin
                            r_cnt   <= 16'd0;
                            r_state <= S_GAP_D;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                    S_GAP_D: begin
                        if (r_cnt == DATA_GAP_LAST) begin
                            r_cnt   <= 16'd0;
                            r_state <= S_DATA;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                    S_DATA: begin
                        r_tx        <= {130'b0, (r_phase ? r_ct : PLAINTEXT)};
                        r_spi_start <= 1'b1;
                        r_cnt       <= 16'd0;
                        r_state     <= S_DATA_W;
                    end
                    S_DATA_W: begin
                        if (w_done_edge) begin
                            r_cnt   <= 16'd0;
                            r_state <= S_GAP_R;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                    S_GAP_R: begin
                        if (r_cnt == RX_GAP_LAST) begin
                            r_cnt   <= 16'd0;
                            r_state <= S_RX;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                    // The receive frame re-sends whatever spi_tx already holds.
                    S_RX: begin
                        r_spi_start <= 1'b1;
                        r_cnt       <= 16'd0;
                        r_state     <= S_RX_W;
                    end
                    S_RX_W: begin
                        if (w_done_edge) begin
                            r_rx    <= spi_rx;
                            r_cnt   <= 16'd0;
                            r_state <= S_CHECK;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                    S_CHECK: begin
                        if (!r_phase) begin
                            r_ct    <= r_rx;
                            r_phase <= 1'b1;
                            r_state <= S_KEY;
                        end else begin
                            r_vec_pass_cnt <= r_vec_pass_cnt + 2'd1;
                            r_phase        <= 1'b0;
                            r_cnt          <= 16'd0;
                            r_state        <= S_NEXT;
                        end
                    end
                    S_NEXT: begin
                        if (r_mode && (r_idx < 2'd2)) begin
                            if (r_cnt == NEXT_GAP_LAST) begin
                                r_idx   <= r_idx + 2'd1;
                                r_phase <= 1'b0;
                                r_cnt   <= 16'd0;
                                r_state <= S_KEY;
                            end else begin
                                r_cnt <= r_cnt + 16'd1;
                            end
                        end else begin
                            r_pass  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign spi_start    = r_spi_start;
    assign spi_sel      = r_phase;
    assign spi_tx       = r_tx;
    assign busy         = r_busy;
    assign pass         = r_pass;
    assign fail         = r_fail;
    assign fail_code    = r_fail_code;
    assign fail_vec     = r_fail_vec;
    assign vec_pass_cnt = r_vec_pass_cnt;

endmodule

// File: tb/tb_aes_selftest_seq.sv
// Bench for aes_selftest_seq: a stub AES/SPI responder plus an expected-frame model
// built from the vector table and the round-trip rules.
module tb_aes_selftest_seq;
    localparam int GAP = 80;
    localparam int RXG = 70;
    localparam int TO  = 100;
    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         mode = 1'b0;
    logic [1:0]   vec_sel = 2'd0;
    logic         spi_done = 1'b0;
    logic [0:127] spi_rx = '0;
    logic         spi_start;
    logic         spi_sel;
    logic [0:257] spi_tx;
    logic         busy;
    logic         pass;
    logic         fail;
    logic [2:0]   fail_code;
    logic [1:0]   fail_vec;
    logic [1:0]   vec_pass_cnt;

    aes_selftest_seq #(
        .GAP_CYCLES(GAP), .RX_GAP_CYCLES(RXG), .TIMEOUT_CYCLES(TO), .CHECK_CT(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .vec_sel(vec_sel),
        .spi_done(spi_done), .spi_rx(spi_rx), .spi_start(spi_start), .spi_sel(spi_sel),
        .spi_tx(spi_tx), .busy(busy), .pass(pass), .fail(fail), .fail_code(fail_code),
        .fail_vec(fail_vec), .vec_pass_cnt(vec_pass_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [258:0] act, input logic [258:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [255:0] key_of(input int v);
        int nb;
        logic [255:0] k;
        nb = 16 + 8 * v;
        k = '0;
        for (int b = 0; b < nb; b++) k[8*(nb-1-b) +: 8] = 8'(b);
        return k;
    endfunction

    function automatic logic [127:0] ct_of(input int v);
        case (v)
            0:       return 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
            1:       return 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
            default: return 128'h8ea2b7ca516745bfeafc49904b496089;
        endcase
    endfunction

    // Responder: 0 = answers like real AES cores, 1 = never raises done, 2 = done held high
    int resp_mode   = 0;
    int corrupt_vec = -1;
    int n_xfer      = 0;
    int pend        = 0;
    int done_cyc    = -1;
    int first_cyc   = -1;
    int key_code    = 0;
    bit stable      = 1'b1;
    logic [127:0] result;
    logic [127:0] pend_rx;
    logic [257:0] t;
    logic [257:0] cur_tx;
    logic         cur_sel;
    logic [258:0] seen_q[$];
    logic [258:0] exp_q[$];

    function automatic logic [127:0] stub_aes(input logic sel, input int k, input logic [127:0] blk);
        if (!sel) begin
            if (blk != PT) return ~blk;
            return (k == corrupt_vec) ? (ct_of(k) ^ 128'h1) : ct_of(k);
        end
        return (blk == ct_of(k)) ? PT : ~PT;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            pend = 0;
            if (resp_mode != 2) spi_done = 1'b0;
        end else begin
            if (resp_mode != 2) spi_done = 1'b0;
            if (pend > 0) begin
                if (spi_tx !== cur_tx || spi_sel !== cur_sel) stable = 1'b0;
                pend--;
                if (pend == 0) begin
                    check("frame_stable", 259'(stable), 259'(1));
                    spi_rx   = pend_rx;
                    spi_done = 1'b1;
                    done_cyc = cyc + 1;
                end
            end
            if (spi_start === 1'b1) begin
                t = spi_tx;
                seen_q.push_back({spi_sel, t});
                if (first_cyc < 0) first_cyc = cyc;
                case (n_xfer % 3)
                    0: key_code = int'(t[257:256]);
                    1: begin
                        check("key_to_data_gap", 259'(cyc - done_cyc), 259'(GAP));
                        result = stub_aes(spi_sel, key_code, t[127:0]);
                    end
                    default: check("data_to_rx_gap", 259'(cyc - done_cyc), 259'(RXG));
                endcase
                cur_tx  = t;
                cur_sel = spi_sel;
                stable  = 1'b1;
                if (resp_mode == 0) begin
                    pend    = int'($urandom_range(3, 40));
                    pend_rx = (n_xfer % 3 == 2) ? result : {$urandom, $urandom, $urandom, $urandom};
                end
                n_xfer++;
            end
        end
    end

    // Expected frame list and outcome, derived from the run rules.
    task automatic build_expected(input int m, input int vs, input int cv,
                                  output int e_pass, output int e_code, output int e_vec,
                                  output int e_cnt);
        int first;
        int last;
        logic [257:0] kf;
        logic [257:0] df;
        exp_q.delete();
        e_cnt = 0;
        if (m == 0 && vs == 3) begin
            e_pass = 0; e_code = 1; e_vec = 3;
            return;
        end
        first = (m != 0) ? 0 : vs;
        last  = (m != 0) ? 2 : vs;
        for (int v = first; v <= last; v++) begin
            for (int ph = 0; ph < 2; ph++) begin
                kf = {2'(v), key_of(v)};
                df = {130'b0, (ph != 0) ? ct_of(v) : PT};
                exp_q.push_back({1'(ph), kf});
                exp_q.push_back({1'(ph), df});
                exp_q.push_back({1'(ph), df});
                if (ph == 0 && v == cv) begin
                    e_pass = 0; e_code = 3; e_vec = v;
                    return;
                end
            end
            e_cnt++;
        end
        e_pass = 1; e_code = 0; e_vec = 0;
    endtask

    typedef struct {
        int mode; int vsel; int corrupt;
        int exp_pass; int exp_code; int exp_vec; int exp_cnt; int exp_pulses;
    } vec_t;

    vec_t tbl[7];

    task automatic run_case(input vec_t c, input string tag);
        int acc;
        int waited;
        int mp; int mc; int mv; int mn;
        build_expected(c.mode, c.vsel, c.corrupt, mp, mc, mv, mn);
        corrupt_vec = c.corrupt;
        resp_mode   = 0;
        @(negedge clk);
        n_xfer = 0; seen_q.delete(); done_cyc = -1; first_cyc = -1;
        mode = c.mode[0]; vec_sel = c.vsel[1:0]; start = 1'b1;
        @(posedge clk); #1;
        acc = cyc;
        start = 1'b0;
        check({tag, "_busy_after_accept"}, 259'(busy), 259'(c.exp_code != 1));
        waited = 0;
        while (busy && waited < 20000) begin
            @(posedge clk); #1;
            waited++;
        end
        check({tag, "_busy_dropped"}, 259'(busy), 259'(0));
        check({tag, "_one_flag_at_drop"}, 259'(pass ^ fail), 259'(1));
        repeat (5) @(posedge clk);
        #1;
        check({tag, "_pass"}, 259'(pass), 259'(c.exp_pass));
        check({tag, "_fail"}, 259'(fail), 259'(c.exp_pass == 0));
        check({tag, "_fail_code"}, 259'(fail_code), 259'(c.exp_code));
        check({tag, "_fail_vec"}, 259'(fail_vec), 259'(c.exp_vec));
        check({tag, "_vec_pass_cnt"}, 259'(vec_pass_cnt), 259'(c.exp_cnt));
        check({tag, "_pulses"}, 259'(seen_q.size()), 259'(c.exp_pulses));
        check({tag, "_model_pulses"}, 259'(seen_q.size()), 259'(exp_q.size()));
        if (seen_q.size() > 0) check({tag, "_first_start_cycle"}, 259'(first_cyc - acc), 259'(1));
        for (int i = 0; i < exp_q.size() && i < seen_q.size(); i++)
            check($sformatf("%s_frame%0d", tag, i), seen_q[i], exp_q[i]);
        $display("run %s mode=%0d vsel=%0d corrupt=%0d -> pass=%0b fail_code=%0d fail_vec=%0d cnt=%0d pulses=%0d",
                 tag, c.mode, c.vsel, c.corrupt, pass, fail_code, fail_vec, vec_pass_cnt, seen_q.size());
    endtask

    task automatic run_timeout(input int vs, input string tag);
        int acc;
        int waited;
        @(negedge clk);
        n_xfer = 0; seen_q.delete();
        mode = 1'b0; vec_sel = vs[1:0]; start = 1'b1;
        @(posedge clk); #1;
        acc = cyc;
        start = 1'b0;
        waited = 0;
        while (!fail && waited < 500) begin
            @(posedge clk); #1;
            waited++;
        end
        check({tag, "_fail_cycle"}, 259'(cyc - acc), 259'(TO + 1));
        check({tag, "_fail_code"}, 259'(fail_code), 259'(2));
        check({tag, "_fail_vec"}, 259'(fail_vec), 259'(vs));
        check({tag, "_busy"}, 259'(busy), 259'(0));
        check({tag, "_pass"}, 259'(pass), 259'(0));
        check({tag, "_pulses"}, 259'(n_xfer), 259'(1));
        $display("run %s vsel=%0d -> fail=%0b fail_code=%0d after %0d cycles",
                 tag, vs, fail, fail_code, cyc - acc);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t c;
        int waited;
        int m; int vs; int cv; int ep; int ec; int ev; int en;

        tbl[0] = '{0, 0, -1, 1, 0, 0, 1, 6};
        tbl[1] = '{0, 1, -1, 1, 0, 0, 1, 6};
        tbl[2] = '{0, 2, -1, 1, 0, 0, 1, 6};
        tbl[3] = '{1, 0, -1, 1, 0, 0, 3, 18};
        tbl[4] = '{0, 3, -1, 0, 1, 3, 0, 0};
        tbl[5] = '{1, 0,  1, 0, 3, 1, 1, 9};
        tbl[6] = '{0, 2,  2, 0, 3, 2, 0, 3};

        repeat (3) @(posedge clk);
        #1;
        check("rst_spi_start", 259'(spi_start), 259'(0));
        check("rst_spi_sel", 259'(spi_sel), 259'(0));
        check("rst_spi_tx", 259'(spi_tx), 259'(0));
        check("rst_busy", 259'(busy), 259'(0));
        check("rst_pass", 259'(pass), 259'(0));
        check("rst_fail", 259'(fail), 259'(0));
        check("rst_fail_code", 259'(fail_code), 259'(0));
        check("rst_fail_vec", 259'(fail_vec), 259'(0));
        check("rst_vec_pass_cnt", 259'(vec_pass_cnt), 259'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 7; i++) run_case(tbl[i], $sformatf("tbl%0d", i));

        for (int i = 0; i < 6; i++) begin
            m  = int'($urandom_range(0, 1));
            vs = int'($urandom_range(0, 3));
            cv = int'($urandom_range(0, 5));
            if (cv > 2) cv = -1;
            build_expected(m, vs, cv, ep, ec, ev, en);
            c = '{m, vs, cv, ep, ec, ev, en, exp_q.size()};
            run_case(c, $sformatf("rnd%0d", i));
        end

        // Reset while vector 1 waits for its encrypt data frame to finish.
        corrupt_vec = -1;
        resp_mode = 0;
        @(negedge clk);
        n_xfer = 0; seen_q.delete(); done_cyc = -1; first_cyc = -1;
        mode = 1'b1; vec_sel = 2'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        waited = 0;
        while (n_xfer < 8 && waited < 5000) begin
            @(posedge clk); #1;
            waited++;
        end
        check("midrst_reached_data_w", 259'(n_xfer), 259'(8));
        check("midrst_cnt_before", 259'(vec_pass_cnt), 259'(1));
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_busy", 259'(busy), 259'(0));
        check("midrst_spi_start", 259'(spi_start), 259'(0));
        check("midrst_spi_sel", 259'(spi_sel), 259'(0));
        check("midrst_spi_tx", 259'(spi_tx), 259'(0));
        check("midrst_pass_fail", 259'({pass, fail}), 259'(0));
        check("midrst_fail_code", 259'(fail_code), 259'(0));
        check("midrst_fail_vec", 259'(fail_vec), 259'(0));
        check("midrst_vec_pass_cnt", 259'(vec_pass_cnt), 259'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        check("midrst_no_more_starts", 259'(n_xfer), 259'(8));
        $display("run midrst -> busy=%0b pulses=%0d", busy, n_xfer);

        resp_mode = 1;
        run_timeout(0, "timeout_silent");

        @(negedge clk);
        resp_mode = 2;
        spi_done = 1'b1;
        repeat (3) @(posedge clk);
        run_timeout(1, "timeout_held_high");
        @(negedge clk);
        resp_mode = 0;
        spi_done = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/aes_selftest_seq.md
# aes_selftest_seq

Synthesizable built-in self-test sequencer for the AES-over-SPI subsystem. Drives `SPI_Main` to run encrypt/decrypt round-trips through `AES_Encrypt` (sel=0) and `AES_Decrypt` (sel=1) against an internal table of three FIPS-197 vectors (AES-128/192/256). Each vector is checked twice: ciphertext against the known answer, then recovered plaintext against the original. Supports single-vector or run-all mode, configurable inter-frame gaps, per-transfer timeout and detailed failure reporting.

## Interface
Parameters:
- `GAP_CYCLES`, 80: idle cycles between a done edge and the next key/data frame start.
- `RX_GAP_CYCLES`, 70: idle cycles before a receive frame start.
- `TIMEOUT_CYCLES`, 8192: maximum cycles waiting for a done edge; range 2..65535.
- `CHECK_CT`, 1: 1 = compare ciphertext with the known answer; 0 = skip that compare.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: level; sampled only in IDLE.
- `mode` in 1: 0 = single vector `vec_sel`; 1 = vectors 0,1,2 in order.
- `vec_sel` in [1:0]: 0 = AES-128, 1 = AES-192, 2 = AES-256, 3 = invalid.
- `spi_done` in 1: `SPI_Main` done.
- `spi_rx` in [0:127]: `SPI_Main` receive data.
- `spi_start` out 1: one-cycle start pulse to `SPI_Main`.
- `spi_sel` out 1: 0 = encryptor, 1 = decryptor.
- `spi_tx` out [0:257]: frame to `SPI_Main`.
- `busy` out 1: run in progress.
- `pass` out 1: sticky; all selected vectors passed.
- `fail` out 1: sticky; run aborted.
- `fail_code` out [2:0]: 0 = none, 1 = bad vec_sel, 2 = timeout, 3 = CT mismatch, 4 = PT mismatch.
- `fail_vec` out [1:0]: index of the failing vector.
- `vec_pass_cnt` out [1:0]: vectors fully passed in the current run.

## Operation
- Vector table:
  - Key bytes are 00,01,02,… for 16/24/32 bytes.
  - Plaintext is 00112233445566778899aabbccddeeff for all vectors.
  - Expected CT: 69c4e0d86a7b0430d8cdb78070b4c55a, dda97ca4864cdfe06eaf70a0ec0d7191, 8ea2b7ca516745bfeafc49904b496089.
- Frame formats:
  - Key frame = {size_code[1:0], key right-aligned in 256 bits, zero-filled above}; size_code = vector index.
  - Data frame = 128-bit block right-aligned in 258 bits, upper 130 bits zero.
- States: IDLE, KEY, KEY_W, GAP_D, DATA, DATA_W, GAP_R, RX, RX_W, CHECK, NEXT.
- `phase` bit: 0 = encrypt pass, 1 = decrypt pass; `spi_sel` = `phase`.
- Transitions:
  - IDLE → KEY on `start`=1 (vec index = 0 if `mode`=1, else `vec_sel`; phase=0).
  - KEY → KEY_W.
  - KEY_W → GAP_D.
  - GAP_D → DATA after `GAP_CYCLES`.
  - DATA → DATA_W; data frame = plaintext (phase 0) or captured CT (phase 1).
  - DATA_W → GAP_R.
  - GAP_R → RX after `RX_GAP_CYCLES`.
  - RX → RX_W; `spi_tx` holds the previous frame.
  - RX_W → CHECK; `spi_rx` is captured on the done-edge cycle.
  - CHECK, phase 0: CT compare when `CHECK_CT`=1 (mismatch → fail code 3); otherwise phase=1, go to KEY.
  - CHECK, phase 1: PT compare (mismatch → fail code 4); otherwise increment `vec_pass_cnt`, go to NEXT.
  - NEXT: if `mode`=1 and index<2, index+1, phase=0, wait `GAP_CYCLES`, go to KEY; otherwise set `pass`, go to IDLE.
- Done edge = `spi_done`=1 while registered previous `spi_done`=0. Levels without an edge are ignored.
- `vec_sel`=3 with `mode`=0 → fail code 1 on the accepting edge; no `spi_start` is issued.
- Any failure: `fail`=1, `fail_code` and `fail_vec` latched, `busy`=0, return to IDLE.
- `start` is ignored while busy. Accepting a new start clears `pass`, `fail`, `fail_code`, `fail_vec` and `vec_pass_cnt`.

## Timing
- Reset values:
  - `spi_start`, `spi_sel`, `busy`, `pass`, `fail` = 0.
  - `spi_tx`, `fail_code`, `fail_vec`, `vec_pass_cnt` = 0.
  - state = IDLE, all counters = 0.
- Reset mid-run:
  - Immediate return to reset values; no further `spi_start`.
- Start acceptance:
  - Accept `start` at edge N → `busy`=1 after edge N.
  - First `spi_start` is high for exactly the cycle after edge N+1.
- Frame stability:
  - `spi_tx` and `spi_sel` are valid in the `spi_start` cycle.
  - Both stay stable until the corresponding done edge.
- Gaps:
  - Done edge at edge M → next `spi_start` high after edge M+GAP (GAP_CYCLES or RX_GAP_CYCLES).
- Timeout:
  - Counter resets on entering any _W state.
  - No done edge within `TIMEOUT_CYCLES` edges → fail code 2.
  - A done edge on the same edge as the counter reaching the limit counts as done.
- Completion:
  - `pass`/`fail` assert on the same edge `busy` drops.
  - Exactly one of them is set per run.
- Pulse count: 6 `spi_start` pulses per vector, with `spi_sel` sequence 0,0,0,1,1,1.

## Test plan
- Reset: assert `rst_n`=0 mid-run (during DATA_W of vector 1) → all outputs 0 next cycle; no `spi_start` until a new `start`.
- Single AES-128 with real `SPI_Main` and AES cores, `mode`=0, `vec_sel`=0 → 6 start pulses (sel 0,0,0,1,1,1), `pass`=1, `vec_pass_cnt`=1, `fail_code`=0.
- Run-all, `mode`=1 → 18 pulses; key frame size codes 00, 01, 10; `pass`=1, `vec_pass_cnt`=3.
- `mode`=0, `vec_sel`=3 → `fail`=1, `fail_code`=1, `busy` never high after the edge, zero `spi_start` pulses.
- Stub responder returns a corrupted CT for vector 1, `mode`=1 → `fail_code`=3, `fail_vec`=1, `vec_pass_cnt`=1, no sel=1 frames for vector 1.
- Stub never raises `spi_done`, `TIMEOUT_CYCLES`=100 → `fail_code`=2 exactly 100 edges after entering KEY_W. Then, with `spi_done` held high for the whole run (no edge), → timeout again.
